// File: rtl/acc_wb_pkg.sv
// Shared types and default widths for the accumulator writeback stage.
// Optional feature macro: ACC_WB_SATCNT_EN (saturation event counter).
package acc_wb_pkg;

  localparam int ACC_W_D = 32;          // signed accumulator / bias width
  localparam int DW_D    = 16;          // signed output word width
  localparam int AW_D    = 10;          // output buffer address width
  // Two bits of headroom: one for acc+bias, one for the rounding add.
  localparam int SUM_W   = ACC_W_D + 2;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    LASTROW
  } wb_state_e;

  // One pipeline slot: a data beat, an end-of-frame token, or empty.
  typedef struct packed {
    logic                    valid;
    logic                    eof;
    logic                    bank;
    logic [AW_D-1:0]         addr;
    logic signed [SUM_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/acc_wb_if.sv
// Beat bus from out_ctrl and write bus to the ping-pong output buffer.
// master = upstream/buffer side, slave = acc_writeback.
interface acc_wb_if
  import acc_wb_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int DW    = DW_D,
  parameter int AW    = AW_D
) ();

  logic                    outr;
  logic                    outrf;
  logic [AW-1:0]           oa;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias;

  logic                    wr_v;
  logic                    wr_bank;
  logic [AW-1:0]           wr_a;
  logic [DW-1:0]           wr_d;

  modport master (
    output outr, outrf, oa, acc, bias,
    input  wr_v, wr_bank, wr_a, wr_d
  );

  modport slave (
    input  outr, outrf, oa, acc, bias,
    output wr_v, wr_bank, wr_a, wr_d
  );

endinterface

// File: rtl/acc_writeback_requant_sat.sv
// Combinational requantiser split across two pipeline stages:
//   S2 half: round half up and arithmetic right shift of the biased sum;
//   S3 half: optional ReLU, then clamp to the signed DW range.
module requant_sat
  import acc_wb_pkg::*;
#(
  parameter int DW = DW_D,
  parameter int SW = SUM_W
) (
  input  logic signed [SW-1:0] i_sum,
  input  logic [4:0]           i_qshift,
  output logic signed [SW-1:0] o_shv,
  input  logic signed [SW-1:0] i_shv,
  input  logic                 i_relu_en,
  output logic [DW-1:0]        o_data,
  output logic                 o_sat
);

  localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [SW-1:0] w_rnd;

  // Rounding constant is half an output LSB; no rounding when unshifted.
  assign w_rnd = (i_qshift != 5'd0) ? (SW'(1) << (i_qshift - 5'd1)) : '0;
  assign o_shv = (i_sum + w_rnd) >>> i_qshift;

  // ReLU takes precedence; otherwise clamp and flag any clipping.
  // NOTE: every output gets a default first so no path through the ifs infers a latch.
  always_comb begin
    o_data = i_shv[DW-1:0];
    o_sat  = 1'b0;
    if (i_relu_en && i_shv[SW-1]) begin
      o_data = '0;
    end else if (i_shv > MAXV) begin
      o_data = MAXV[DW-1:0];
      o_sat  = 1'b1;
    end else if (i_shv < MINV) begin
      o_data = MINV[DW-1:0];
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/acc_writeback.sv
// Writeback stage behind out_ctrl: bias add, requantise, ReLU, saturate and
// write into the selected ping-pong bank, with a fixed 3-cycle latency and a
// one-cycle s_fin per frame. Optional macro ACC_WB_SATCNT_EN adds sat_cnt.
// Beat struct widths follow the package defaults.
module acc_writeback
  import acc_wb_pkg::*;
#(
  parameter int ACC_W = ACC_W_D,
  parameter int DW    = DW_D,
  parameter int AW    = AW_D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  acc_wb_if.slave     bus,
  input  logic [4:0]  qshift,
  input  logic        relu_en,
  input  logic        outp,
  output logic        s_fin,
  output logic        busy
`ifdef ACC_WB_SATCNT_EN
  ,
  output logic [15:0] sat_cnt
`endif
);

  localparam int SW = SUM_W;

  wb_state_e            r_state, w_state_nxt;
  logic                 w_eof_inj;
  logic                 w_clr;
  logic                 r_bank;
  logic                 w_beat_bank;
  logic signed [SW-1:0] w_acc_x, w_bias_x, w_sum, w_shv;
  logic [DW-1:0]        w_data;
  logic                 w_sat;
  beat_t                r_s1, r_s2;
  logic                 r_wr_v, r_wr_bank, r_s_fin;
  logic [AW-1:0]        r_wr_a;
  logic [DW-1:0]        r_wr_d;

  // Dropping run behaves exactly like reset: everything in flight is discarded.
  assign w_clr = reset | ~run;

  // Next state and end-of-frame token injection.
  always_comb begin
    w_state_nxt = r_state;
    w_eof_inj   = 1'b0;
    case (r_state)
      IDLE:    if (bus.outr) w_state_nxt = bus.outrf ? LASTROW : FRAME;
      FRAME:   if (bus.outr && bus.outrf) w_state_nxt = LASTROW;
      LASTROW: if (!bus.outr) begin
                 w_eof_inj   = 1'b1;
                 w_state_nxt = IDLE;
               end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (w_clr) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Bank is latched on the first beat of a frame; outp is ignored afterwards.
  always_ff @(posedge clk) begin
    if (w_clr)                            r_bank <= 1'b0;
    else if (r_state == IDLE && bus.outr) r_bank <= outp;
  end

  // The opening beat must carry the new bank before the latch updates.
  assign w_beat_bank = (r_state == IDLE) ? outp : r_bank;

  // Sign-extend into the headroom width; the sum cannot overflow.
  assign w_acc_x  = {{(SW-ACC_W){bus.acc[ACC_W-1]}},  bus.acc};
  assign w_bias_x = {{(SW-ACC_W){bus.bias[ACC_W-1]}}, bus.bias};
  assign w_sum    = w_acc_x + w_bias_x;

  requant_sat #(.DW(DW), .SW(SW)) u_requant (
    .i_sum     (r_s1.data),
    .i_qshift  (qshift),
    .o_shv     (w_shv),
    .i_shv     (r_s2.data),
    .i_relu_en (relu_en),
    .o_data    (w_data),
    .o_sat     (w_sat)
  );

  // Three fixed pipeline stages; eof tokens ride along in empty slots.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_wr_v    <= 1'b0;
      r_wr_bank <= 1'b0;
      r_wr_a    <= '0;
      r_wr_d    <= '0;
      r_s_fin   <= 1'b0;
    end else begin
      r_s1      <= '{valid: bus.outr, eof: w_eof_inj, bank: w_beat_bank,
                     addr: bus.oa, data: w_sum};
      r_s2      <= '{valid: r_s1.valid, eof: r_s1.eof, bank: r_s1.bank,
                     addr: r_s1.addr, data: w_shv};
      r_wr_v    <= r_s2.valid;
      r_wr_bank <= r_s2.bank;
      r_wr_a    <= r_s2.addr;
      r_wr_d    <= w_data;
      r_s_fin   <= r_s2.eof;
    end
  end

  assign bus.wr_v    = r_wr_v;
  assign bus.wr_bank = r_wr_bank;
  assign bus.wr_a    = r_wr_a;
  assign bus.wr_d    = r_wr_d;
  assign s_fin       = r_s_fin;
  assign busy        = (r_state != IDLE) | r_s1.valid | r_s1.eof |
                       r_s2.valid | r_s2.eof | r_wr_v | r_s_fin;

`ifdef ACC_WB_SATCNT_EN
  logic [15:0] r_sat_cnt;

  // Counts clipped writes as they are issued; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (w_clr)
      r_sat_cnt <= '0;
    else if (r_s2.valid && w_sat && r_sat_cnt != 16'hFFFF)
      r_sat_cnt <= r_sat_cnt + 16'd1;
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_acc_writeback.sv
// Directed self-checking bench for acc_writeback (optionally ACC_WB_SATCNT_EN).
module tb_acc_writeback;
  import acc_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [4:0]  qshift;
  logic        relu_en, outp;
  logic        s_fin, busy;
`ifdef ACC_WB_SATCNT_EN
  logic [15:0] sat_cnt;
`endif

  acc_wb_if bus ();

  acc_writeback dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .bus     (bus),
    .qshift  (qshift),
    .relu_en (relu_en),
    .outp    (outp),
    .s_fin   (s_fin),
    .busy    (busy)
`ifdef ACC_WB_SATCNT_EN
    ,
    .sat_cnt (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit bank;
    int addr;
    int data;
  } wr_rec_t;

  wr_rec_t wq[$];
  int      fq[$];

  // Log every write and every s_fin with the cycle it is visible in.
  always @(negedge clk) begin
    if (bus.wr_v === 1'b1)
      wq.push_back('{cyc, bus.wr_bank, int'(bus.wr_a), int'($signed(bus.wr_d))});
    if (s_fin === 1'b1) fq.push_back(cyc);
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.outr  = 1'b0;
    bus.outrf = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input int addr, input bit rf);
    bus.outr  = 1'b1;
    bus.outrf = rf;
    bus.acc   = a;
    bus.bias  = b;
    bus.oa    = addr[9:0];
  endtask

  // One-beat frame: write visible at t+3, s_fin at t+4.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] qs, input bit relu, input int addr, input int exp_d);
    qshift  = qs;
    relu_en = relu;
    beat(a, b, addr, 1'b1);
    tick();
    idle();
    tick();
    tick();
    check({tag, "_wr_v"}, bus.wr_v, 1);
    check({tag, "_wr_a"}, bus.wr_a, addr);
    check({tag, "_wr_d"}, $signed(bus.wr_d), exp_d);
    tick();
    check({tag, "_s_fin"}, s_fin, 1);
    check({tag, "_wr_v_after"}, bus.wr_v, 0);
    tick();
    tick();
  endtask

  int t0;

  initial begin
    reset = 1'b1; run = 1'b1; qshift = '0; relu_en = 1'b0; outp = 1'b0;
    bus.acc = '0; bus.bias = '0; bus.oa = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    check("rst_wr_v", bus.wr_v, 0);
    check("rst_s_fin", s_fin, 0);
    check("rst_busy", busy, 0);
`ifdef ACC_WB_SATCNT_EN
    check("rst_sat_cnt", sat_cnt, 0);
`endif
    tick();

    // Rounding, shifting, ReLU and clamping on single beats.
    single("t1", 32'd1000, 32'd24, 5'd3, 1'b1, 5, 128);
    single("t2", -32'sd13, 32'd0, 5'd2, 1'b0, 6, -3);
    single("t2r", -32'sd13, 32'd0, 5'd2, 1'b1, 7, 0);
    single("qs31", -32'sd1, 32'd0, 5'd31, 1'b0, 8, 0);
`ifdef ACC_WB_SATCNT_EN
    check("pre_sat_cnt", sat_cnt, 0);
`endif
    single("t3", 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 9, 32767);
`ifdef ACC_WB_SATCNT_EN
    check("t3_sat_cnt", sat_cnt, 1);
`endif
    single("negsat", 32'h8000_0000, -32'sd1000, 5'd4, 1'b0, 10, -32768);
    single("edge_max", 32'd32767, 32'd0, 5'd0, 1'b0, 11, 32767);
`ifdef ACC_WB_SATCNT_EN
    check("edge_sat_cnt", sat_cnt, 2);
`endif

    // 12-beat frame into bank 1; outp flipped mid-frame must be ignored.
    wq.delete(); fq.delete();
    qshift = 5'd4; relu_en = 1'b0; outp = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      beat(32'(i * 16), 32'd0, 100 + i, i >= 8);
      tick();
      if (i == 0) outp = 1'b0;
    end
    idle();
    repeat (8) tick();
    check("t4_nwr", wq.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < wq.size()) begin
        check($sformatf("t4_bank%0d", i), wq[i].bank, 1);
        check($sformatf("t4_addr%0d", i), wq[i].addr, 100 + i);
        check($sformatf("t4_data%0d", i), wq[i].data, i);
        check($sformatf("t4_cyc%0d", i), wq[i].cyc, t0 + 3 + i);
      end
    end
    check("t4_nfin", fq.size(), 1);
    if (fq.size() > 0) check("t4_fin_cyc", fq[0], t0 + 15);
    check("t4_busy_end", busy, 0);

    // run dropped mid-frame: pipeline flushed, no s_fin, then a clean frame.
    wq.delete(); fq.delete();
    qshift = 5'd0; outp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat(32'(i), 32'd0, 200 + i, 1'b0);
      tick();
    end
    run = 1'b0;
    idle();
    tick();
    check("t5_wr_v", bus.wr_v, 0);
    check("t5_busy", busy, 0);
    check("t5_s_fin", s_fin, 0);
    repeat (3) tick();
    run = 1'b1;
    repeat (10) tick();
    check("t5_nfin", fq.size(), 0);
    check("t5_nwr_before_drop", wq.size(), 3);
    wq.delete(); fq.delete();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      beat(32'(7 + i), 32'd0, 220 + i, i == 2);
      tick();
    end
    idle();
    repeat (8) tick();
    check("t5b_nwr", wq.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < wq.size()) check($sformatf("t5b_data%0d", i), wq[i].data, 7 + i);
    check("t5b_nfin", fq.size(), 1);
    if (fq.size() > 0) check("t5b_fin_cyc", fq[0], t0 + 6);

    // Back-to-back frames with a bank flip between them.
    wq.delete(); fq.delete();
    qshift = 5'd0; outp = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      beat(32'(50 + i), 32'd0, 300 + i, i == 2);
      tick();
    end
    idle();
    outp = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      beat(32'(60 + i), 32'd0, 310 + i, i == 2);
      tick();
    end
    idle();
    repeat (8) tick();
    check("t6_nwr", wq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq.size()) begin
        check($sformatf("t6_bank%0d", i), wq[i].bank, (i < 3) ? 0 : 1);
        check($sformatf("t6_data%0d", i), wq[i].data, (i < 3) ? 50 + i : 57 + i);
        check($sformatf("t6_addr%0d", i), wq[i].addr, (i < 3) ? 300 + i : 307 + i);
      end
    end
    check("t6_nfin", fq.size(), 2);
    if (fq.size() > 0) check("t6_finA_cyc", fq[0], t0 + 6);
    if (fq.size() > 1) check("t6_finB_cyc", fq[1], t0 + 10);
    check("t6_busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
